// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus IDLE/EXEC/HOLD sequencer that drives an external combinational
// ALU from registers and captures its result into a tagged valid/ready output register.
module alu_cmd_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_cin,
    input  logic             in_bin,
    input  logic [1:0]       in_sel,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic             alu_cin,
    output logic             alu_bin,
    output logic [1:0]       alu_sel,
    input  logic [2*N-1:0]   alu_y,
    input  logic             alu_cout,
    input  logic             alu_bout,
    input  logic             alu_gr,
    input  logic             alu_le,
    input  logic             alu_eq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_y,
    output logic             out_cout,
    output logic             out_bout,
    output logic [2:0]       out_flags,
    output logic [1:0]       out_sel,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic             cin;
        logic             bin;
        logic [1:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    state_t           state_q, state_d;
    logic [N-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d, alu_bin_q, alu_bin_d;
    logic [1:0]       alu_sel_q, alu_sel_d, exec_sel_q, exec_sel_d;
    logic [TAG_W-1:0] exec_tag_q, exec_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [2*N-1:0]   out_y_q, out_y_d;
    logic             out_cout_q, out_cout_d, out_bout_q, out_bout_d;
    logic [2:0]       out_flags_q, out_flags_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             full, empty, push, pop;
    cmd_t             head;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_cnt_d   = tag_cnt_q;
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_bin_d   = alu_bin_q;
        alu_sel_d   = alu_sel_q;
        exec_sel_d  = exec_sel_q;
        exec_tag_d  = exec_tag_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_cout_d  = out_cout_q;
        out_bout_d  = out_bout_q;
        out_flags_d = out_flags_q;
        out_sel_d   = out_sel_q;
        out_tag_d   = out_tag_q;
        push        = in_valid && !full;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_y_d     = alu_y;
                out_cout_d  = alu_cout;
                out_bout_d  = alu_bout;
                out_flags_d = {alu_gr, alu_le, alu_eq};
                out_sel_d   = exec_sel_q;
                out_tag_d   = exec_tag_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            alu_a_d    = head.a;
            alu_b_d    = head.b;
            alu_cin_d  = head.cin;
            alu_bin_d  = head.bin;
            alu_sel_d  = head.sel;
            exec_sel_d = head.sel;
            exec_tag_d = head.tag;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{a: in_a, b: in_b, cin: in_cin, bin: in_bin,
                                sel: in_sel, tag: tag_cnt_q};
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            tag_cnt_d = tag_cnt_q + TAG_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage holds data only; emptiness is tracked by count_q, so no reset needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_cnt_q   <= '0;
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_bin_q   <= 1'b0;
            alu_sel_q   <= '0;
            exec_sel_q  <= '0;
            exec_tag_q  <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_cout_q  <= 1'b0;
            out_bout_q  <= 1'b0;
            out_flags_q <= '0;
            out_sel_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_cnt_q   <= tag_cnt_d;
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_bin_q   <= alu_bin_d;
            alu_sel_q   <= alu_sel_d;
            exec_sel_q  <= exec_sel_d;
            exec_tag_q  <= exec_tag_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_cout_q  <= out_cout_d;
            out_bout_q  <= out_bout_d;
            out_flags_q <= out_flags_d;
            out_sel_q   <= out_sel_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_bin   = alu_bin_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_cout  = out_cout_q;
    assign out_bout  = out_bout_q;
    assign out_flags = out_flags_q;
    assign out_sel   = out_sel_q;
    assign out_tag   = out_tag_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential front/back end for the combinational 8-bit ALU. It accepts ALU commands (operands, carry/borrow in, op select) over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU inputs from registers, then captures the ALU result and flags into a tagged output register presented over a valid/ready handshake. It sits directly upstream of the ALU, feeding it, and also consumes what the ALU produces.

Parameters:
N, 8, operand width; the ALU result width is 2*N.
DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.
TAG_W, 4, width of the per-command sequence tag.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  command present.
in_ready  output  1  FIFO can accept; equals !full.
in_a  input  N  operand A.
in_b  input  N  operand B.
in_cin  input  1  carry in (add).
in_bin  input  1  borrow in (subtract).
in_sel  input  2  op: 0 add, 1 sub, 2 compare, 3 square A.
alu_a  output  N  registered operand to ALU A.
alu_b  output  N  registered operand to ALU B.
alu_cin  output  1  registered carry in to ALU Cin.
alu_bin  output  1  registered borrow in to ALU Bin.
alu_sel  output  2  registered select to ALU sel.
alu_y  input  2*N  ALU result Y.
alu_cout  input  1  ALU Cout.
alu_bout  input  1  ALU Bout.
alu_gr  input  1  ALU gr flag.
alu_le  input  1  ALU le flag.
alu_eq  input  1  ALU eq flag.
out_valid  output  1  result register holds an unconsumed result.
out_ready  input  1  consumer accepts the result.
out_y  output  2*N  captured Y.
out_cout  output  1  captured Cout.
out_bout  output  1  captured Bout.
out_flags  output  3  captured {gr, le, eq}.
out_sel  output  2  op that produced this result.
out_tag  output  TAG_W  sequence tag of this command.

Behaviour:
- Reset (rst_n low at an edge): FIFO emptied; read/write pointers, count and tag counter set to 0; FSM goes to IDLE. All alu_* and out_* outputs go to 0, including out_valid. Pushes are ignored while rst_n is low. Reset mid-operation discards any in-flight or unconsumed result.
- Push: on in_valid && in_ready, the entry {a, b, cin, bin, sel, tag_cnt} is written, then tag_cnt increments modulo 2^TAG_W.
- FIFO has no bypass. in_ready = !full, so a push while full is impossible; in_valid while full holds off. Push and pop in the same cycle leave the count unchanged.
- FSM states IDLE, EXEC, HOLD:
  - IDLE: if the FIFO is non-empty, pop the head into the alu_* registers and an internal tag/sel register, then go to EXEC. Otherwise stay.
  - EXEC: the ALU settles for one full cycle. At the edge, capture alu_y, alu_cout, alu_bout, {alu_gr, alu_le, alu_eq} and the held sel/tag into out_*; set out_valid=1; go to HOLD.
  - HOLD: out_* are stable while out_valid && !out_ready. On out_ready, if the FIFO is non-empty, pop the next entry in the same edge, clear out_valid, and go to EXEC. If the FIFO is empty, clear out_valid and go to IDLE.
- alu_* keep their last value outside EXEC. No combinational path exists from alu_* inputs to out_*.
- Latency, with the pipe empty: command accepted at edge t0, popped at t1, out_valid high after t2. Peak throughput is one result per 2 cycles.
- out_y width is 2*N and is taken verbatim from the ALU. The sequencer does not zero-extend or interpret it.
- Tags wrap from 2^TAG_W - 1 to 0. Results leave in strict acceptance order.
- FIFO pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).

Test Plan:
- Add: push a=F0, b=20, cin=1, sel=0. Expect out_y=0x0011, out_cout=1, out_tag=0, and out_valid rising 2 cycles after the accept edge.
- Sub and compare back-to-back, with out_ready held high: push sub a=10, b=20, bin=0, then compare a=05, b=05. Expect first out_y=0x00F0 with out_bout=1, then out_y=0x0001 with out_flags=001. Results are spaced exactly 2 cycles apart with tags 0 and 1.
- Square: push a=FF, sel=3. Expect out_y=0xFE01.
- Backpressure, with out_ready=0 and in_valid held: exactly 1+DEPTH=5 commands are accepted and in_ready drops. out_* stay constant while out_ready is low. Releasing out_ready drains all 5 in order with tags 0..4.
- Tag wrap: issue 17 commands. Expect tags 0..15, then 0.
- Reset mid-operation: assert rst_n=0 for one edge while in HOLD with 3 entries queued. Expect out_valid=0, in_ready=1, no stale result, and the next command to produce tag 0.
